// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and level irq.
// Define UART_TX_PARITY_EN to add an optional parity bit (CTRL[3:2]).
module mmio_uart_tx #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   BASE_ADDR  = 32'h0000_1000,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [15:0]        DIV_RESET  = 16'd867
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic [1:0]       bhw,
    output logic [WIDTH-1:0] rdata,
    output logic             sel,
    output logic             tx,
    output logic             irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, empty, overflow;
    logic [15:0]   div;
    logic          tx_en, irq_en;
`ifdef UART_TX_PARITY_EN
    logic          parity_en, odd;
    logic          par, par_n;
`endif

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, bit_div, bit_div_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        tx_n, pop, push, load, bound, busy;
    logic [1:0]  idx;
    logic        wr;
    logic        unused;

    assign sel    = (addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    assign idx    = addr[3:2];
    assign wr     = sel && we;
    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign push   = wr && (idx == 2'd0) && !full;
    assign busy   = (state != IDLE);
    assign bound  = (cnt == bit_div);
    assign unused = ^{bhw, addr[1:0], wdata};

    // Next-state logic; a finished stop bit chains straight into the next start.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_div_n = bit_div;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        tx_n      = tx;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                load  = tx_en && !empty;
            end
            START: begin
                if (bound) begin
                    cnt_n     = '0;
                    bit_div_n = div;
                    tx_n      = shreg[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bound) begin
                    cnt_n     = '0;
                    bit_div_n = div;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
`ifdef UART_TX_PARITY_EN
                        if (parity_en) begin
                            tx_n    = par ^ odd;
                            state_n = PARITY;
                        end
`endif
                    end else begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bound) begin
                    cnt_n     = '0;
                    bit_div_n = div;
                    tx_n      = 1'b1;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (bound) begin
                    cnt_n     = '0;
                    bit_div_n = div;
                    tx_n      = 1'b1;
                    state_n   = IDLE;
                    load      = tx_en && !empty;
                end
            end
            default: state_n = IDLE;
        endcase
        pop = load;
        if (load) begin
            shreg_n   = mem[rd_ptr];
            bit_div_n = div;
            cnt_n     = '0;
            tx_n      = 1'b0;
            state_n   = START;
`ifdef UART_TX_PARITY_EN
            par_n     = ^mem[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_div <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            irq     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_div <= bit_div_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
            irq     <= irq_en && empty && !busy;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    // Fullness is taken before the pop, so a push to a full FIFO always drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DIV_RESET;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en <= 1'b0;
            odd       <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr) begin
                case (idx)
                    2'd0: if (full) overflow <= 1'b1;
                    2'd1: if (wdata[3]) overflow <= 1'b0;
                    2'd2: div <= wdata[15:0];
                    default: begin
                        tx_en  <= wdata[0];
                        irq_en <= wdata[1];
`ifdef UART_TX_PARITY_EN
                        parity_en <= wdata[2];
                        odd       <= wdata[3];
`endif
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && !we) begin
            case (idx)
                2'd1: begin
                    rdata[3:0]    = {overflow, busy, empty, full};
                    rdata[8 +: CW] = count;
                end
                2'd2: rdata[15:0] = div;
                2'd3: begin
                    rdata[1:0] = {irq_en, tx_en};
`ifdef UART_TX_PARITY_EN
                    rdata[3:2] = {odd, parity_en};
`endif
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level line model plus directed literal checks.
// Parity checks compile in when UART_TX_PARITY_EN is defined.
module tb_mmio_uart_tx;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [27:0] BASE_HI = 28'h0000100;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_ST    = BASE + 32'd4;
    localparam logic [31:0] A_BD    = BASE + 32'd8;
    localparam logic [31:0] A_CT    = BASE + 32'd12;
`ifdef UART_TX_PARITY_EN
    localparam logic [3:0]  CMASK   = 4'hF;
`else
    localparam logic [3:0]  CMASK   = 4'h3;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we    = 1'b0;
    logic [1:0]  bhw   = 2'b10;
    logic [31:0] rdata;
    logic        sel, tx, irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .WIDTH(32), .BASE_ADDR(32'h0000_1000),
        .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
        .bhw(bhw), .rdata(rdata), .sel(sel), .tx(tx), .irq(irq)
    );

    // Line model: a frame is a list of bit values, each held div+1 clocks.
    logic [7:0]  mq [$];
    logic        m_ovf    = 1'b0;
    logic [15:0] m_div    = 16'd867;
    logic [3:0]  m_ctrl   = 4'h0;
    logic        m_active = 1'b0;
    logic        m_tx     = 1'b1;
    logic        m_irq    = 1'b0;
    int          m_pos, m_rem, m_nbits;
    logic        m_bits [0:10];

    task automatic start_frame(input logic [7:0] b);
        logic pen;
        pen = (CMASK[2] && m_ctrl[2]);
        m_nbits = pen ? 11 : 10;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
        if (pen) m_bits[9] = (^b) ^ m_ctrl[3];
        m_bits[m_nbits-1] = 1'b1;
        m_pos = 0;
        m_rem = int'(m_div) + 1;
        m_tx = 1'b0;
        m_active = 1'b1;
    endtask

    task automatic model_step();
        logic wr_hit, full_pre, irq_n;
        wr_hit   = we && (addr[31:4] == BASE_HI);
        full_pre = (mq.size() == DEPTH);
        irq_n    = m_ctrl[1] && (mq.size() == 0) && !m_active;
        if (m_active) begin
            m_rem--;
            if (m_rem == 0) begin
                m_pos++;
                if (m_pos == m_nbits) m_active = 1'b0;
                else begin
                    m_rem = int'(m_div) + 1;
                    m_tx  = m_bits[m_pos];
                end
            end
        end
        if (!m_active) begin
            if (m_ctrl[0] && mq.size() > 0) start_frame(mq.pop_front());
            else m_tx = 1'b1;
        end
        if (wr_hit) begin
            case (addr[3:2])
                2'd0: if (full_pre) m_ovf = 1'b1; else mq.push_back(wdata[7:0]);
                2'd1: if (wdata[3]) m_ovf = 1'b0;
                2'd2: m_div = wdata[15:0];
                default: m_ctrl = wdata[3:0] & CMASK;
            endcase
        end
        m_irq = irq_n;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0; m_div = 16'd867; m_ctrl = 4'h0;
            m_active = 1'b0; m_tx = 1'b1; m_irq = 1'b0;
        end else begin
            model_step();
        end
    end

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == DEPTH);
        s[1] = (mq.size() == 0);
        s[2] = m_active;
        s[3] = m_ovf;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:4] == BASE_HI) begin
            case (a[3:2])
                2'd1: r = m_status();
                2'd2: r = {16'h0, m_div};
                2'd3: r = {28'h0, m_ctrl};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    initial forever begin
        @(negedge clk);
        checks++;
        if (tx !== m_tx || irq !== m_irq) begin
            failures++;
            $display("FAIL line t=%0t tx=%b want=%b irq=%b want=%b",
                     $time, tx, m_tx, irq, m_irq);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; addr = '0;
    endtask

    task automatic rd(input logic [31:0] a, input string name);
        @(negedge clk);
        addr = a; we = 1'b0;
        #1;
        chk(name, rdata, m_read(a));
    endtask

    task automatic rd_lit(input logic [31:0] a, input logic [31:0] exp,
                          input string name);
        @(negedge clk);
        addr = a; we = 1'b0;
        #1;
        chk(name, rdata, exp);
    endtask

    logic cap   [0:47];
    logic c_irq [0:47];

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // reset values and decode
        rd_lit(A_ST, 32'h0000_0002, "rst_status");
        rd_lit(A_BD, 32'd867, "rst_baud");
        rd_lit(A_CT, 32'h0, "rst_ctrl");
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd_lit(BASE + 32'd6, 32'h0000_0002, "status_low_bits_ignored");
        chk("sel_hit", {31'h0, sel}, 32'h1);
        rd_lit(32'h0000_2004, 32'h0, "miss_rdata");
        chk("sel_miss", {31'h0, sel}, 32'h0);
        wr(A_CT, 32'hFFFF_FFFF);
        rd_lit(A_CT, {28'h0, CMASK}, "ctrl_mask");
        rd(A_CT, "ctrl_model");
        wr(A_CT, 32'h0);

        // single frame 0x55, DIV=3
        wr(A_BD, 32'd3);
        wr(A_CT, 32'h1);
        wr(A_TX, 32'h55);
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            addr = A_ST; we = 1'b0;
            #1;
            cap[i] = tx;
            if (i == 40) chk("busy_at_40", {31'h0, rdata[2]}, 32'h1);
            if (i == 41) chk("busy_at_41", {31'h0, rdata[2]}, 32'h0);
        end
        chk("f55_idle0",  {31'h0, cap[0]},  32'h1);
        chk("f55_start",  {31'h0, cap[1]},  32'h0);
        chk("f55_start4", {31'h0, cap[4]},  32'h0);
        chk("f55_bit0",   {31'h0, cap[5]},  32'h1);
        chk("f55_bit1",   {31'h0, cap[9]},  32'h0);
        chk("f55_bit7",   {31'h0, cap[36]}, 32'h0);
        chk("f55_stop",   {31'h0, cap[37]}, 32'h1);
        rd_lit(A_ST, 32'h0000_0002, "f55_done_status");

        // overflow then drain in order
        wr(A_CT, 32'h0);
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h11 + i);
        rd_lit(A_ST, 32'h0000_0409, "ovf_status");
        rd(A_ST, "ovf_model");
        wr(A_ST, 32'h8);
        rd_lit(A_ST, 32'h0000_0401, "ovf_cleared");
        wr(A_BD, 32'd1);
        wr(A_CT, 32'h1);
        repeat (90) @(negedge clk);
        rd_lit(A_ST, 32'h0000_0002, "drain_status");

        // disable mid-frame
        wr(A_CT, 32'h0);
        wr(A_TX, 32'hA1);
        wr(A_TX, 32'hA2);
        wr(A_TX, 32'hA3);
        wr(A_CT, 32'h1);
        repeat (4) @(negedge clk);
        rd(A_ST, "dis_busy");
        wr(A_CT, 32'h0);
        repeat (30) @(negedge clk);
        rd_lit(A_ST, 32'h0000_0200, "dis_status");
        chk("dis_tx_high", {31'h0, tx}, 32'h1);
        wr(A_CT, 32'h1);
        repeat (45) @(negedge clk);
        rd_lit(A_ST, 32'h0000_0002, "dis_drained");

        // back-to-back frames and irq, DIV=0
        wr(A_BD, 32'd0);
        wr(A_CT, 32'h3);
        repeat (2) @(negedge clk);
        chk("irq_idle", {31'h0, irq}, 32'h1);
        wr(A_TX, 32'hA5);
        wr(A_TX, 32'h3C);
        for (int i = 1; i < 24; i++) begin
            @(negedge clk);
            cap[i] = tx;
            c_irq[i] = irq;
        end
        chk("b2b_start1", {31'h0, cap[1]},  32'h0);
        chk("b2b_bit0a",  {31'h0, cap[2]},  32'h1);
        chk("b2b_stop1",  {31'h0, cap[10]}, 32'h1);
        chk("b2b_start2", {31'h0, cap[11]}, 32'h0);
        chk("b2b_bit0b",  {31'h0, cap[12]}, 32'h0);
        chk("b2b_stop2",  {31'h0, cap[20]}, 32'h1);
        chk("b2b_irq1",   {31'h0, c_irq[1]},  32'h0);
        chk("b2b_irq21",  {31'h0, c_irq[21]}, 32'h0);
        chk("b2b_irq22",  {31'h0, c_irq[22]}, 32'h1);

`ifdef UART_TX_PARITY_EN
        // parity: even then odd on 0x07, DIV=1
        wr(A_BD, 32'd1);
        for (int k = 0; k < 2; k++) begin
            wr(A_CT, (k == 0) ? 32'h5 : 32'hD);
            wr(A_TX, 32'h07);
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                addr = A_ST; we = 1'b0;
                #1;
                cap[i] = tx;
                if (i == 22) chk("par_busy_22", {31'h0, rdata[2]}, 32'h1);
                if (i == 23) chk("par_busy_23", {31'h0, rdata[2]}, 32'h0);
            end
            chk("par_bit7", {31'h0, cap[17]}, 32'h0);
            chk("par_bit",  {31'h0, cap[19]}, (k == 0) ? 32'h1 : 32'h0);
            chk("par_stop", {31'h0, cap[21]}, 32'h1);
        end
        rd_lit(A_CT, 32'hD, "par_ctrl");
`endif

        // reset mid-frame aborts and clears state
        wr(A_BD, 32'd3);
        wr(A_CT, 32'h1);
        wr(A_TX, 32'h00);
        wr(A_TX, 32'h01);
        wr(A_TX, 32'h02);
        repeat (2) @(negedge clk);
        chk("pre_rst_tx", {31'h0, tx}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", {31'h0, tx}, 32'h1);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        rd_lit(A_ST, 32'h0000_0002, "rst2_status");
        rd_lit(A_BD, 32'd867, "rst2_baud");
        rd_lit(A_CT, 32'h0, "rst2_ctrl");
        repeat (20) @(negedge clk);
        chk("rst2_tx_idle", {31'h0, tx}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
